// File: rtl/oled_spi_driver_pkg.sv
// Shared FSM encoding, transfer sizes and the SSD1306 power-up command ROM.
package oled_pkg;

  typedef enum logic [2:0] {
    RES_PULSE,
    RES_WAIT,
    INIT,
    IDLE,
    FRAME
  } state_t;

  localparam int INIT_LEN    = 25;
  localparam int FRAME_BYTES = 1024;

  // 20 00 selects horizontal addressing, so frames wrap without address commands.
  function automatic logic [7:0] init_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    return 8'hAE;
      5'd1:    return 8'hD5;
      5'd2:    return 8'h80;
      5'd3:    return 8'hA8;
      5'd4:    return 8'h3F;
      5'd5:    return 8'hD3;
      5'd6:    return 8'h00;
      5'd7:    return 8'h40;
      5'd8:    return 8'h8D;
      5'd9:    return 8'h14;
      5'd10:   return 8'h20;
      5'd11:   return 8'h00;
      5'd12:   return 8'hA1;
      5'd13:   return 8'hC8;
      5'd14:   return 8'hDA;
      5'd15:   return 8'h12;
      5'd16:   return 8'h81;
      5'd17:   return 8'hCF;
      5'd18:   return 8'hD9;
      5'd19:   return 8'hF1;
      5'd20:   return 8'hDB;
      5'd21:   return 8'h40;
      5'd22:   return 8'hA4;
      5'd23:   return 8'hA6;
      5'd24:   return 8'hAF;
      default: return 8'hE3;
    endcase
  endfunction

endpackage

// File: rtl/oled_spi_driver_if.sv
// Bundle of the image-controller handshake and the OLED SPI pins.
interface oled_spi_driver_if;
  logic       enable;
  logic [7:0] data_to_send;
  logic [9:0] byte_counter;
  logic       frame_done;
  logic       oled_sclk;
  logic       oled_mosi;
  logic       oled_cs_n;
  logic       oled_dc;
  logic       oled_res_n;

  modport master (
    input  enable, data_to_send,
    output byte_counter, frame_done, oled_sclk, oled_mosi, oled_cs_n, oled_dc, oled_res_n
  );

  modport slave (
    output enable, data_to_send,
    input  byte_counter, frame_done, oled_sclk, oled_mosi, oled_cs_n, oled_dc, oled_res_n
  );
endinterface

// File: rtl/oled_spi_driver_byte_tx.sv
// Shifts one byte out MSB first as SPI mode 0; done pulses in the last cycle
// of the final SCLK-high half so the caller can chain the next byte seamlessly.
module spi_byte_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       sclk,
  output logic       mosi,
  output logic       done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    sr;
  logic          busy;
  logic          half_end;

  assign half_end = (div_cnt == DW'(CLK_DIV - 1));
  assign done     = busy && sclk && half_end && (bit_cnt == 3'd7);

  // Half-period divider; MOSI advances on each SCLK fall so it is stable a full low half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      busy    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (start) begin
      sr      <= tx_byte[6:0];
      mosi    <= tx_byte[7];
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk <= 1'b0;
          if (bit_cnt == 3'd7) begin
            busy <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            mosi    <= sr[6];
            sr      <= {sr[5:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/oled_spi_driver.sv
// SSD1306 driver: panel reset, 25-byte init burst, then continuous 1024-byte frames.
//
// state     | meaning
// RES_PULSE | hold oled_res_n low for RST_CYCLES
// RES_WAIT  | oled_res_n high, wait RST_CYCLES before talking to the panel
// INIT      | command burst (dc=0) of the init ROM bytes
// IDLE      | cs_n high, SCLK idle; start a frame when enable is high
// FRAME     | data burst (dc=1) of bytes 0..1023, then frame_done
//
// Each byte in INIT/FRAME is LOAD (ld_ph 0..2) then SHIFT (ld_ph 3).
module oled_spi_driver
  import oled_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 20000
) (
  input logic               clk,
  input logic               rst,
  oled_spi_driver_if.master bus
);

  localparam int TW = $clog2(RST_CYCLES + 1);

  state_t        state;
  logic [TW-1:0] tmr;
  logic [4:0]    rom_idx;
  logic [1:0]    ld_ph;
  logic [9:0]    byte_counter;
  logic          frame_done;
  logic          cs_n;
  logic          dc;
  logic          res_n;

  logic          tx_start;
  logic          tx_done;
  logic          tx_sclk;
  logic          tx_mosi;
  logic [7:0]    tx_byte;

  // Third LOAD cycle: data_to_send has had one cycle of margin after the controller's register.
  assign tx_start = ((state == INIT) || (state == FRAME)) && (ld_ph == 2'd2);
  assign tx_byte  = (state == INIT) ? init_rom(rom_idx) : bus.data_to_send;

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .start   (tx_start),
    .tx_byte (tx_byte),
    .sclk    (tx_sclk),
    .mosi    (tx_mosi),
    .done    (tx_done)
  );

  // Sequencer: reset timing, burst framing and byte indexing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RES_PULSE;
      tmr          <= '0;
      rom_idx      <= '0;
      ld_ph        <= '0;
      byte_counter <= '0;
      frame_done   <= 1'b0;
      cs_n         <= 1'b1;
      dc           <= 1'b0;
      res_n        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        RES_PULSE: begin
          res_n <= 1'b0;
          if (tmr == TW'(RST_CYCLES - 1)) begin
            tmr   <= '0;
            res_n <= 1'b1;
            state <= RES_WAIT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RES_WAIT: begin
          if (tmr == TW'(RST_CYCLES - 1)) begin
            tmr     <= '0;
            rom_idx <= '0;
            ld_ph   <= '0;
            dc      <= 1'b0;
            state   <= INIT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        INIT: begin
          cs_n <= 1'b0;
          dc   <= 1'b0;
          if (ld_ph != 2'd3) begin
            ld_ph <= ld_ph + 2'd1;
          end else if (tx_done) begin
            ld_ph <= '0;
            if (rom_idx == 5'(INIT_LEN - 1)) begin
              rom_idx <= '0;
              cs_n    <= 1'b1;
              state   <= IDLE;
            end else begin
              rom_idx <= rom_idx + 5'd1;
            end
          end
        end
        IDLE: begin
          cs_n <= 1'b1;
          if (bus.enable) begin
            dc    <= 1'b1;
            ld_ph <= '0;
            state <= FRAME;
          end
        end
        FRAME: begin
          cs_n <= 1'b0;
          if (ld_ph != 2'd3) begin
            ld_ph <= ld_ph + 2'd1;
          end else if (tx_done) begin
            ld_ph        <= '0;
            byte_counter <= byte_counter + 10'd1;
            if (byte_counter == 10'(FRAME_BYTES - 1)) begin
              cs_n       <= 1'b1;
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= RES_PULSE;
      endcase
    end
  end

  assign bus.byte_counter = byte_counter;
  assign bus.frame_done   = frame_done;
  assign bus.oled_sclk    = tx_sclk;
  assign bus.oled_mosi    = tx_mosi;
  assign bus.oled_cs_n    = cs_n;
  assign bus.oled_dc      = dc;
  assign bus.oled_res_n   = res_n;

endmodule

// File: tb/tb_oled_spi_driver.sv
// Scoreboard bench for oled_spi_driver: expected SPI bytes are queued when a
// burst is launched and an SPI monitor pops and compares every captured byte.
module tb_oled_spi_driver;

  localparam int CLK_DIV    = 2;
  localparam int RST_CYCLES = 8;
  localparam int BYTE_CYC   = 3 + 16 * CLK_DIV;
  localparam int FRAME_CYC  = 1024 * BYTE_CYC + 1;

  typedef struct packed {
    logic [7:0] data;
    logic       dc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  oled_spi_driver_if bus();

  oled_spi_driver #(.CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t       exp_q[$];
  logic [7:0] rom [25];
  logic [7:0] pattern [1024];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_cap    = 0;
  int         n_fd     = 0;
  int         cyc      = 0;
  int         nbits    = 0;
  logic [7:0] sh;
  logic       fd_prev  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Registered image-controller stub.
  always @(posedge clk) bus.data_to_send <= pattern[bus.byte_counter];

  always @(posedge clk) cyc++;

  // SPI monitor: mode 0 sampling, MSB first, only while selected.
  always @(posedge bus.oled_sclk) begin
    exp_t e;
    if (bus.oled_cs_n === 1'b0) begin
      sh = {sh[6:0], bus.oled_mosi};
      nbits++;
      if (nbits == 8) begin
        nbits = 0;
        n_cap++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: actual %0h required none", sh);
        end else begin
          e = exp_q.pop_front();
          check("byte_data", sh, e.data);
          check("byte_dc", bus.oled_dc, e.dc);
        end
      end
    end
  end

  // A deselect discards any partial byte.
  always @(posedge bus.oled_cs_n) nbits = 0;

  // frame_done must be a single-cycle pulse with byte_counter already wrapped.
  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) begin
      n_fd++;
      check("fd_width", fd_prev, 0);
      check("bc_wrap", bus.byte_counter, 0);
    end
    fd_prev = bus.frame_done;
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_sclk"}, bus.oled_sclk, 0);
    check({tag, "_mosi"}, bus.oled_mosi, 0);
    check({tag, "_cs_n"}, bus.oled_cs_n, 1);
    check({tag, "_dc"}, bus.oled_dc, 0);
    check({tag, "_res_n"}, bus.oled_res_n, 0);
    check({tag, "_bc"}, bus.byte_counter, 0);
    check({tag, "_fd"}, bus.frame_done, 0);
  endtask

  task automatic reset_and_init();
    int k;
    int viol;
    int cap0;
    rst = 1'b1;
    bus.enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    exp_q.delete();
    for (int i = 0; i < 25; i++) exp_q.push_back({rom[i], 1'b0});
    cap0 = n_cap;
    rst = 1'b0;
    k = 0;
    while (bus.oled_res_n !== 1'b1 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("res_low_cycles", k, RST_CYCLES);
    while (bus.oled_cs_n !== 1'b0 && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check("cs_fall_cycles", k, 2 * RST_CYCLES + 1);
    check("init_dc", bus.oled_dc, 0);
    k = 0;
    while (exp_q.size() != 0 && k < 30 * BYTE_CYC) begin
      @(posedge clk); #1; k++;
    end
    check("init_bytes_left", exp_q.size(), 0);
    k = 0;
    while (bus.oled_cs_n !== 1'b1 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("init_cs_rise", bus.oled_cs_n, 1);
    viol = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.oled_sclk !== 1'b0 || bus.oled_cs_n !== 1'b1) viol++;
    end
    check("init_idle_quiet", viol, 0);
    check("init_count", n_cap - cap0, 25);
  endtask

  initial begin
    int k;
    int t1;
    int t2;
    int viol;
    int base;
    rom = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
            8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
            8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    for (int n = 0; n < 1024; n++) pattern[n] = 8'(n) ^ 8'h5A;
    rst = 1'b1;
    bus.enable = 1'b0;

    reset_and_init();

    // Frame 1 (byte N = N^0x5A), enable held so frame 2 follows back-to-back.
    base = n_cap;
    for (int n = 0; n < 1024; n++) exp_q.push_back({pattern[n], 1'b1});
    @(negedge clk);
    bus.enable = 1'b1;
    k = 0;
    while (bus.frame_done !== 1'b1 && k < FRAME_CYC + 200) begin
      @(posedge clk); #1; k++;
    end
    check("fd1_seen", bus.frame_done, 1);
    check("fd1_cs_n", bus.oled_cs_n, 1);
    t1 = cyc;

    // Frame 2 keeps byte 0 = 0x5A; the rest is random and read long after this update.
    for (int n = 1; n < 1024; n++) pattern[n] = 8'($urandom);
    for (int n = 0; n < 1024; n++) exp_q.push_back({pattern[n], 1'b1});
    k = 0;
    while (bus.byte_counter !== 10'd500 && k < FRAME_CYC) begin
      @(posedge clk); #1; k++;
    end
    check("bc_reach_500", bus.byte_counter, 500);
    @(negedge clk);
    bus.enable = 1'b0;
    k = 0;
    while (bus.frame_done !== 1'b1 && k < FRAME_CYC + 200) begin
      @(posedge clk); #1; k++;
    end
    check("fd2_seen", bus.frame_done, 1);
    t2 = cyc;
    check("frame_period", t2 - t1, FRAME_CYC);

    viol = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (bus.oled_cs_n !== 1'b1 || bus.oled_sclk !== 1'b0 || bus.frame_done !== 1'b0) viol++;
    end
    check("idle_persist", viol, 0);
    check("frames_seen", n_fd, 2);
    check("frame_bytes_left", exp_q.size(), 0);
    check("frame_cap_count", n_cap - base, 2048);

    // Frame 3 with fully random data, interrupted by reset during byte 300.
    for (int n = 0; n < 1024; n++) pattern[n] = 8'($urandom);
    base = n_cap;
    for (int n = 0; n < 1024; n++) exp_q.push_back({pattern[n], 1'b1});
    @(negedge clk);
    bus.enable = 1'b1;
    k = 0;
    while (bus.byte_counter !== 10'd300 && k < FRAME_CYC) begin
      @(posedge clk); #1; k++;
    end
    check("bc_reach_300", bus.byte_counter, 300);
    bus.enable = 1'b0;
    k = 0;
    while (bus.oled_sclk !== 1'b1 && k < 2 * BYTE_CYC) begin
      @(posedge clk); #1; k++;
    end
    check("shift_300_active", bus.oled_sclk, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_cs_n", bus.oled_cs_n, 1);
    check("mid_rst_res_n", bus.oled_res_n, 0);
    check("mid_rst_bc", bus.byte_counter, 0);
    check("mid_rst_sclk", bus.oled_sclk, 0);
    check("mid_rst_dc", bus.oled_dc, 0);
    check("mid_rst_bytes_sent", n_cap - base, 300);

    reset_and_init();
    check("frames_after_reinit", n_fd, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
